// File: rtl/hazard_scoreboard_unit_pkg.sv
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared constants, state/cause enums and forward-select helper
// Revision : 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;
  localparam int HZ_CNT_W      = 8;
  localparam int NUM_CAUSES    = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [2:0] {
    LOAD_USE  = 3'd0,
    BRANCH    = 3'd1,
    MD_RAW    = 3'd2,
    MD_WAW    = 3'd3,
    MD_STRUCT = 3'd4
  } stall_cause_e;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  // Memory stage wins over writeback because it holds the younger result
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_MEM;
    else if (hit_w) return FWD_WB;
    else            return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_unit_if.sv
// ============================================================================
// Module   : hazard_scoreboard_unit_if
// Brief    : Pipeline-to-hazard-unit signal bundle with master/slave views
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] Rs_D, Rt_D, Write_Reg_D;
  logic                  Reg_Write_D, Md_Op_D, Branch_D, Branch_Not_Equal_D;
  logic [REG_ADDR_W-1:0] Rs_E, Rt_E, Write_Reg_E, Md_Dest_E;
  logic                  Mem_To_Reg_E, Reg_Write_E, Md_Start_E;
  logic [REG_ADDR_W-1:0] Write_Reg_M, Write_Reg_W;
  logic                  Mem_To_Reg_M, Reg_Write_M, Reg_Write_W;
  logic                  Stall_F, Stall_D, Flush_E;
  logic                  Forward_AD, Forward_BD;
  logic [1:0]            Forward_AE, Forward_BE;
  logic                  Md_Busy, Md_Done;
  logic [REG_ADDR_W-1:0] Md_Wb_Reg;

  modport master (
    output Rs_D, Rt_D, Write_Reg_D, Reg_Write_D, Md_Op_D, Branch_D, Branch_Not_Equal_D,
    output Rs_E, Rt_E, Write_Reg_E, Md_Dest_E, Mem_To_Reg_E, Reg_Write_E, Md_Start_E,
    output Write_Reg_M, Write_Reg_W, Mem_To_Reg_M, Reg_Write_M, Reg_Write_W,
    input  Stall_F, Stall_D, Flush_E, Forward_AD, Forward_BD, Forward_AE, Forward_BE,
    input  Md_Busy, Md_Done, Md_Wb_Reg
  );

  modport slave (
    input  Rs_D, Rt_D, Write_Reg_D, Reg_Write_D, Md_Op_D, Branch_D, Branch_Not_Equal_D,
    input  Rs_E, Rt_E, Write_Reg_E, Md_Dest_E, Mem_To_Reg_E, Reg_Write_E, Md_Start_E,
    input  Write_Reg_M, Write_Reg_W, Mem_To_Reg_M, Reg_Write_M, Reg_Write_W,
    output Stall_F, Stall_D, Flush_E, Forward_AD, Forward_BD, Forward_AE, Forward_BE,
    output Md_Busy, Md_Done, Md_Wb_Reg
  );
endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard_unit_md_scoreboard.sv
// ============================================================================
// Module   : md_scoreboard
// Brief    : Busy/latency tracking and pending-write vector for the MUL/DIV unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int MD_LATENCY = 4
) (
  input  wire logic                       clk_i,
  input  wire logic                       rst_n_i,
  input  wire logic                       md_start_i,
  input  wire logic [REG_ADDR_W-1:0]      md_dest_i,
  output logic      [(2**REG_ADDR_W)-1:0] pend_o,
  output logic                            md_busy_o,
  output logic                            md_done_o,
  output logic      [REG_ADDR_W-1:0]      md_wb_reg_o
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  md_state_e             state_q, state_d;
  logic [HZ_CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] wb_reg_q, wb_reg_d;
  logic [NUM_REGS-1:0]   sb_q, sb_d;
  logic [NUM_REGS-1:0]   issue_vec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      wb_reg_q <= '0;
      sb_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_reg_q <= wb_reg_d;
      sb_q     <= sb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wb_reg_d = wb_reg_q;
    sb_d     = sb_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start_i) begin
          state_d  = MD_RUN;
          cnt_d    = HZ_CNT_W'(MD_LATENCY - 1);
          wb_reg_d = md_dest_i;
          if (md_dest_i != '0) sb_d[md_dest_i] = 1'b1;
        end
      end
      MD_RUN: begin
        // A start seen here is illegal and deliberately dropped
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d          = MD_IDLE;
          sb_d[wb_reg_q]   = 1'b0;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    issue_vec = '0;
    if (md_start_i) issue_vec[md_dest_i] = 1'b1;
    pend_o    = sb_q | issue_vec;
    pend_o[0] = 1'b0;
  end

  assign md_busy_o   = (state_q == MD_RUN);
  assign md_done_o   = (state_q == MD_RUN) && (cnt_q == '0);
  assign md_wb_reg_o = wb_reg_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module   : hazard_scoreboard_unit
// Brief    : MIPS hazard unit: forwarding, stalls, MUL/DIV pending scoreboard.
//            Optional macro HAZARD_PERF_CNT_EN adds the Stall_Cycles counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int MD_LATENCY = 4
) (
  input  wire logic               Clk,
  input  wire logic               Rst_N,
  hazard_scoreboard_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             Stall_Cycles
`endif
);
  localparam int NUM_REGS = 2**REG_ADDR_W;

  logic [NUM_REGS-1:0]   pend;
  logic [NUM_CAUSES-1:0] cause;
  logic                  stall;
  logic                  br_hit_e, br_hit_m;

  md_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .MD_LATENCY (MD_LATENCY)
  ) u_md_scoreboard (
    .clk_i       (Clk),
    .rst_n_i     (Rst_N),
    .md_start_i  (hz.Md_Start_E),
    .md_dest_i   (hz.Md_Dest_E),
    .pend_o      (pend),
    .md_busy_o   (hz.Md_Busy),
    .md_done_o   (hz.Md_Done),
    .md_wb_reg_o (hz.Md_Wb_Reg)
  );

  assign br_hit_e = hz.Reg_Write_E && (hz.Write_Reg_E != '0) &&
                    ((hz.Write_Reg_E == hz.Rs_D) || (hz.Write_Reg_E == hz.Rt_D));
  assign br_hit_m = hz.Mem_To_Reg_M && (hz.Write_Reg_M != '0) &&
                    ((hz.Write_Reg_M == hz.Rs_D) || (hz.Write_Reg_M == hz.Rt_D));

  // Register 0 is masked out of pend, so the scoreboard causes need no extra guard
  always_comb begin
    cause            = '0;
    cause[LOAD_USE]  = hz.Mem_To_Reg_E && (hz.Rt_E != '0) &&
                       ((hz.Rt_E == hz.Rs_D) || (hz.Rt_E == hz.Rt_D));
    cause[BRANCH]    = (hz.Branch_D || hz.Branch_Not_Equal_D) && (br_hit_e || br_hit_m);
    cause[MD_RAW]    = pend[hz.Rs_D] || pend[hz.Rt_D];
    cause[MD_WAW]    = hz.Reg_Write_D && pend[hz.Write_Reg_D];
    cause[MD_STRUCT] = hz.Md_Op_D && (hz.Md_Busy || hz.Md_Start_E);
  end

  assign stall      = Rst_N && (|cause);
  assign hz.Stall_F = stall;
  assign hz.Stall_D = stall;
  assign hz.Flush_E = stall;

  always_comb begin
    hz.Forward_AE = FWD_RF;
    hz.Forward_BE = FWD_RF;
    hz.Forward_AD = 1'b0;
    hz.Forward_BD = 1'b0;
    if (Rst_N) begin
      hz.Forward_AE = fwd_sel(hz.Reg_Write_M && (hz.Rs_E != '0) && (hz.Rs_E == hz.Write_Reg_M),
                              hz.Reg_Write_W && (hz.Rs_E != '0) && (hz.Rs_E == hz.Write_Reg_W));
      hz.Forward_BE = fwd_sel(hz.Reg_Write_M && (hz.Rt_E != '0) && (hz.Rt_E == hz.Write_Reg_M),
                              hz.Reg_Write_W && (hz.Rt_E != '0) && (hz.Rt_E == hz.Write_Reg_W));
      hz.Forward_AD = hz.Reg_Write_M && !hz.Mem_To_Reg_M && (hz.Rs_D != '0) &&
                      (hz.Rs_D == hz.Write_Reg_M);
      hz.Forward_BD = hz.Reg_Write_M && !hz.Mem_To_Reg_M && (hz.Rt_D != '0) &&
                      (hz.Rt_D == hz.Write_Reg_M);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) stall_cycles_q <= '0;
    else        stall_cycles_q <= stall_cycles_d;
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  assign Stall_Cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
// ============================================================================
// Module   : tb_hazard_scoreboard_unit
// Brief    : Self-checking bench for hazard_scoreboard_unit (HAZARD_PERF_CNT_EN aware)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_ADDR_W(AW)) bus ();
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard_unit #(.REG_ADDR_W(AW), .MD_LATENCY(LAT)) dut (
    .Clk   (clk),
    .Rst_N (rst_n),
    .hz    (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .Stall_Cycles (stall_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: an in-flight op is described by its issue cycle and destination
  bit     m_busy = 0;
  int     m_issue = 0, m_dest = 0, m_wb = 0, cyc = 0;
  longint m_stalls = 0;

  logic       e_stall, e_fad, e_fbd, e_busy, e_done;
  logic [1:0] e_fae, e_fbe;
  int         e_wb;

  function automatic bit is_pend(int r);
    return (r != 0) && ((m_busy && m_dest == r) ||
                        (bus.Md_Start_E && int'(bus.Md_Dest_E) == r));
  endfunction

  function automatic logic [1:0] fwd_exp(int src);
    if (src != 0 && bus.Reg_Write_M && src == int'(bus.Write_Reg_M)) return 2'b10;
    if (src != 0 && bus.Reg_Write_W && src == int'(bus.Write_Reg_W)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void compute_exp();
    int  rs, rt;
    bit  lu, br, raw, waw, st;
    rs = int'(bus.Rs_D);
    rt = int'(bus.Rt_D);
    lu  = bus.Mem_To_Reg_E && bus.Rt_E != 0 && (int'(bus.Rt_E) == rs || int'(bus.Rt_E) == rt);
    br  = (bus.Branch_D || bus.Branch_Not_Equal_D) &&
          ((bus.Reg_Write_E && bus.Write_Reg_E != 0 &&
            (int'(bus.Write_Reg_E) == rs || int'(bus.Write_Reg_E) == rt)) ||
           (bus.Mem_To_Reg_M && bus.Write_Reg_M != 0 &&
            (int'(bus.Write_Reg_M) == rs || int'(bus.Write_Reg_M) == rt)));
    raw = is_pend(rs) || is_pend(rt);
    waw = bus.Reg_Write_D && is_pend(int'(bus.Write_Reg_D));
    st  = bus.Md_Op_D && (m_busy || bus.Md_Start_E);
    e_stall = rst_n && (lu || br || raw || waw || st);
    e_fae   = rst_n ? fwd_exp(int'(bus.Rs_E)) : 2'b00;
    e_fbe   = rst_n ? fwd_exp(int'(bus.Rt_E)) : 2'b00;
    e_fad   = rst_n && rs != 0 && bus.Reg_Write_M && !bus.Mem_To_Reg_M && rs == int'(bus.Write_Reg_M);
    e_fbd   = rst_n && rt != 0 && bus.Reg_Write_M && !bus.Mem_To_Reg_M && rt == int'(bus.Write_Reg_M);
    e_busy  = m_busy;
    e_done  = m_busy && (cyc - m_issue == LAT);
    e_wb    = m_wb;
  endfunction

  task automatic clear_inputs();
    bus.Rs_D = '0; bus.Rt_D = '0; bus.Write_Reg_D = '0;
    bus.Reg_Write_D = 0; bus.Md_Op_D = 0; bus.Branch_D = 0; bus.Branch_Not_Equal_D = 0;
    bus.Rs_E = '0; bus.Rt_E = '0; bus.Write_Reg_E = '0; bus.Md_Dest_E = '0;
    bus.Mem_To_Reg_E = 0; bus.Reg_Write_E = 0; bus.Md_Start_E = 0;
    bus.Write_Reg_M = '0; bus.Write_Reg_W = '0;
    bus.Mem_To_Reg_M = 0; bus.Reg_Write_M = 0; bus.Reg_Write_W = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      compute_exp();
      if (e_stall) m_stalls++;
      if (m_busy && (cyc - m_issue == LAT)) m_busy = 0;
      else if (!m_busy && bus.Md_Start_E) begin
        m_busy = 1; m_issue = cyc; m_dest = int'(bus.Md_Dest_E); m_wb = m_dest;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic model_reset();
    m_busy = 0; m_wb = 0; m_stalls = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.Rs_E = 5'd3; bus.Write_Reg_M = 5'd3; bus.Reg_Write_M = 1;
    bus.Mem_To_Reg_E = 1; bus.Rt_E = 5'd8; bus.Rs_D = 5'd8;
    @(negedge clk);
    checks++; if (bus.Forward_AE !== 2'b00) begin errors++; $display("FAIL reset_fwd_ae got=%b exp=00", bus.Forward_AE); end
    checks++; if (bus.Stall_D !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.Stall_D); end
    checks++; if (bus.Md_Busy !== 1'b0 || bus.Md_Done !== 1'b0) begin errors++; $display("FAIL reset_md got busy=%b done=%b exp 0/0", bus.Md_Busy, bus.Md_Done); end
    checks++; if (bus.Md_Wb_Reg !== '0) begin errors++; $display("FAIL reset_wb got=%0d exp=0", bus.Md_Wb_Reg); end
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    clear_inputs();
    bus.Rs_E = 5'd3; bus.Rt_E = 5'd3; bus.Write_Reg_M = 5'd3; bus.Reg_Write_M = 1;
    bus.Write_Reg_W = 5'd3; bus.Reg_Write_W = 1;
    @(negedge clk);
    checks++; if (bus.Forward_AE !== 2'b10) begin errors++; $display("FAIL fwd_ae_mem got=%b exp=10", bus.Forward_AE); end
    checks++; if (bus.Forward_BE !== 2'b10) begin errors++; $display("FAIL fwd_be_mem got=%b exp=10", bus.Forward_BE); end
    tick();
    bus.Reg_Write_M = 0;
    @(negedge clk);
    checks++; if (bus.Forward_AE !== 2'b01) begin errors++; $display("FAIL fwd_ae_wb got=%b exp=01", bus.Forward_AE); end
    tick();
    bus.Reg_Write_M = 1; bus.Rs_E = '0; bus.Write_Reg_M = '0; bus.Write_Reg_W = '0;
    @(negedge clk);
    checks++; if (bus.Forward_AE !== 2'b00 || bus.Stall_D !== 1'b0) begin errors++; $display("FAIL fwd_r0 got fae=%b stall=%b exp 00/0", bus.Forward_AE, bus.Stall_D); end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.Mem_To_Reg_E = 1; bus.Rt_E = 5'd8; bus.Rs_D = 5'd8;
    @(negedge clk);
    checks++; if ({bus.Stall_F, bus.Stall_D, bus.Flush_E} !== 3'b111) begin errors++; $display("FAIL load_use got=%b exp=111", {bus.Stall_F, bus.Stall_D, bus.Flush_E}); end
    tick();
    bus.Rt_E = '0; bus.Rs_D = '0;
    @(negedge clk);
    checks++; if ({bus.Stall_F, bus.Stall_D, bus.Flush_E} !== 3'b000) begin errors++; $display("FAIL load_use_r0 got=%b exp=000", {bus.Stall_F, bus.Stall_D, bus.Flush_E}); end
    tick();
  endtask

  task automatic test_md_raw();
    clear_inputs();
    bus.Md_Start_E = 1; bus.Md_Dest_E = 5'd5; bus.Rs_D = 5'd5;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      checks++; if (bus.Stall_D !== (k <= LAT)) begin errors++; $display("FAIL md_raw_stall c%0d got=%b exp=%b", k, bus.Stall_D, (k <= LAT)); end
      checks++; if (bus.Md_Done !== (k == LAT)) begin errors++; $display("FAIL md_raw_done c%0d got=%b exp=%b", k, bus.Md_Done, (k == LAT)); end
      checks++; if (bus.Md_Busy !== (k >= 1 && k <= LAT)) begin errors++; $display("FAIL md_raw_busy c%0d got=%b exp=%b", k, bus.Md_Busy, (k >= 1 && k <= LAT)); end
      if (k == LAT) begin
        checks++; if (bus.Md_Wb_Reg !== 5'd5) begin errors++; $display("FAIL md_raw_wb got=%0d exp=5", bus.Md_Wb_Reg); end
      end
      tick();
      bus.Md_Start_E = 0;
    end
  endtask

  task automatic test_struct_waw();
    clear_inputs();
    bus.Md_Start_E = 1; bus.Md_Dest_E = 5'd5;
    tick();
    clear_inputs();
    bus.Md_Op_D = 1;
    @(negedge clk);
    checks++; if (bus.Stall_D !== 1'b1) begin errors++; $display("FAIL md_struct got=%b exp=1", bus.Stall_D); end
    tick();
    bus.Md_Op_D = 0; bus.Reg_Write_D = 1; bus.Write_Reg_D = 5'd5;
    @(negedge clk);
    checks++; if (bus.Stall_D !== 1'b1) begin errors++; $display("FAIL md_waw got=%b exp=1", bus.Stall_D); end
    tick();
    bus.Write_Reg_D = 5'd6;
    @(negedge clk);
    checks++; if (bus.Stall_D !== 1'b0) begin errors++; $display("FAIL md_waw_other got=%b exp=0", bus.Stall_D); end
    for (int k = 0; k < LAT; k++) tick();
    @(negedge clk);
    checks++; if (bus.Md_Busy !== 1'b0) begin errors++; $display("FAIL md_struct_idle got=%b exp=0", bus.Md_Busy); end
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.Branch_D = 1; bus.Rs_D = 5'd9; bus.Write_Reg_E = 5'd9; bus.Reg_Write_E = 1;
    @(negedge clk);
    checks++; if (bus.Stall_D !== 1'b1) begin errors++; $display("FAIL branch_stall got=%b exp=1", bus.Stall_D); end
    tick();
    bus.Write_Reg_E = '0; bus.Reg_Write_E = 0; bus.Write_Reg_M = 5'd9; bus.Reg_Write_M = 1;
    @(negedge clk);
    checks++; if (bus.Forward_AD !== 1'b1 || bus.Stall_D !== 1'b0) begin errors++; $display("FAIL branch_fwd got fad=%b stall=%b exp 1/0", bus.Forward_AD, bus.Stall_D); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    clear_inputs();
    bus.Md_Start_E = 1; bus.Md_Dest_E = 5'd7; bus.Rs_D = 5'd7;
    tick();
    bus.Md_Start_E = 0;
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.Md_Busy !== 1'b0 || bus.Stall_D !== 1'b0) begin errors++; $display("FAIL rst_mid got busy=%b stall=%b exp 0/0", bus.Md_Busy, bus.Stall_D); end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      checks++; if (bus.Md_Done !== 1'b0 || bus.Md_Busy !== 1'b0 || bus.Stall_D !== 1'b0) begin
        errors++; $display("FAIL rst_mid_after c%0d got done=%b busy=%b stall=%b exp 0/0/0", k, bus.Md_Done, bus.Md_Busy, bus.Stall_D);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.Rs_D = AW'($urandom_range(0, 3));  bus.Rt_D = AW'($urandom_range(0, 3));
      bus.Write_Reg_D = AW'($urandom_range(0, 3));
      bus.Reg_Write_D = 1'($urandom_range(0, 1)); bus.Md_Op_D = ($urandom_range(0, 3) == 0);
      bus.Branch_D = ($urandom_range(0, 3) == 0); bus.Branch_Not_Equal_D = ($urandom_range(0, 3) == 0);
      bus.Rs_E = AW'($urandom_range(0, 3)); bus.Rt_E = AW'($urandom_range(0, 3));
      bus.Write_Reg_E = AW'($urandom_range(0, 3)); bus.Md_Dest_E = AW'($urandom_range(0, 3));
      bus.Mem_To_Reg_E = ($urandom_range(0, 3) == 0); bus.Reg_Write_E = 1'($urandom_range(0, 1));
      bus.Md_Start_E = ($urandom_range(0, 4) == 0);
      bus.Write_Reg_M = AW'($urandom_range(0, 3)); bus.Write_Reg_W = AW'($urandom_range(0, 3));
      bus.Mem_To_Reg_M = 1'($urandom_range(0, 1)); bus.Reg_Write_M = 1'($urandom_range(0, 1));
      bus.Reg_Write_W = 1'($urandom_range(0, 1));
      @(negedge clk);
      compute_exp();
      checks++; if ({bus.Stall_F, bus.Stall_D, bus.Flush_E} !== {3{e_stall}}) begin errors++; $display("FAIL rnd_stall n%0d got=%b exp=%b", n, {bus.Stall_F, bus.Stall_D, bus.Flush_E}, {3{e_stall}}); end
      checks++; if (bus.Forward_AE !== e_fae || bus.Forward_BE !== e_fbe) begin errors++; $display("FAIL rnd_fwd_e n%0d got=%b/%b exp=%b/%b", n, bus.Forward_AE, bus.Forward_BE, e_fae, e_fbe); end
      checks++; if (bus.Forward_AD !== e_fad || bus.Forward_BD !== e_fbd) begin errors++; $display("FAIL rnd_fwd_d n%0d got=%b/%b exp=%b/%b", n, bus.Forward_AD, bus.Forward_BD, e_fad, e_fbd); end
      checks++; if (bus.Md_Busy !== e_busy || bus.Md_Done !== e_done) begin errors++; $display("FAIL rnd_md n%0d got busy=%b done=%b exp %b/%b", n, bus.Md_Busy, bus.Md_Done, e_busy, e_done); end
      checks++; if (int'(bus.Md_Wb_Reg) != e_wb) begin errors++; $display("FAIL rnd_wb n%0d got=%0d exp=%0d", n, bus.Md_Wb_Reg, e_wb); end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_md_raw();
    test_struct_waw();
    test_branch();
    test_reset_mid_op();
    test_random();
`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk);
    checks++; if (longint'(stall_cycles) != m_stalls) begin errors++; $display("FAIL perf_cnt got=%0d exp=%0d", stall_cycles, m_stalls); end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
